// File: rtl/score_save_pkg.sv
// Shared types and constants for the score_save block: FSM encodings,
// BCD digit width, and a digit saturation helper.
package score_save_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_COMPARE = 3'd2,
    S_WRITE   = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  // Clamp a nibble to a legal BCD digit; garbage codes A-F read as 9.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/score_save_if.sv
// Timer <-> score_save handshake: done/doneSave four-phase pair plus the
// game score digits that are valid while done is high.
interface score_save_if;
  import score_save_pkg::*;

  logic             done;
  logic [BCD_W-1:0] score_ten;
  logic [BCD_W-1:0] score_one;
  logic             doneSave;

  // Timer side drives the request and score, sees the acknowledge.
  modport master (output done, score_ten, score_one, input doneSave);
  // Score saver side.
  modport slave  (input done, score_ten, score_one, output doneSave);

endinterface

// File: rtl/score_save_flash.sv
// New-record blinker: once started, toggles record_flash every FLASH_PERIOD
// cycles for FLASH_TOGGLES toggles, finishing low. A capture aborts it.
module score_save_flash #(
  parameter int FLASH_PERIOD  = 25_000_000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  output logic record_flash
);

  localparam int CW = (FLASH_PERIOD  > 1) ? $clog2(FLASH_PERIOD)      : 1;
  localparam int TW = $clog2(FLASH_TOGGLES + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(FLASH_PERIOD - 1);
  localparam logic [TW-1:0] TGL_LAST = TW'(FLASH_TOGGLES - 1);

  logic [CW-1:0] cyc_cnt;
  logic [TW-1:0] tgl_cnt;
  logic          running;

  // Half-period counter and toggle counter; abort outranks start since a
  // fresh capture must always silence the display.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cyc_cnt      <= '0;
      tgl_cnt      <= '0;
      running      <= 1'b0;
      record_flash <= 1'b0;
    end else if (abort) begin
      cyc_cnt      <= '0;
      tgl_cnt      <= '0;
      running      <= 1'b0;
      record_flash <= 1'b0;
    end else if (start) begin
      cyc_cnt      <= '0;
      tgl_cnt      <= '0;
      running      <= 1'b1;
      record_flash <= 1'b0;
    end else if (running) begin
      if (cyc_cnt == CYC_LAST) begin
        cyc_cnt      <= '0;
        record_flash <= ~record_flash;
        tgl_cnt      <= tgl_cnt + 1'b1;
        // Even toggle count guarantees the last toggle leaves the flag low.
        if (tgl_cnt == TGL_LAST) running <= 1'b0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_save.sv
// High-score keeper on the responder end of the timer done/doneSave
// handshake. Control FSM sequences capture -> compare -> (write) -> ack;
// datapath holds captured digits and the stored high score.
module score_save
  import score_save_pkg::*;
#(
  parameter int HIGH_INIT_TEN = 0,
  parameter int HIGH_INIT_ONE = 0,
  parameter int FLASH_PERIOD  = 25_000_000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic             clk,
  input  logic             resetn,
  score_save_if.slave      tmr,
  input  logic             clear_high,
  output logic [BCD_W-1:0] high_ten,
  output logic [BCD_W-1:0] high_one,
  output logic             new_record,
  output logic             record_flash,
  output logic             busy
);

  localparam logic [BCD_W-1:0] INIT_TEN = BCD_W'(HIGH_INIT_TEN);
  localparam logic [BCD_W-1:0] INIT_ONE = BCD_W'(HIGH_INIT_ONE);

  state_t           state, nxt;
  logic [BCD_W-1:0] cap_ten, cap_one;
  logic             greater;
  logic             do_capture, do_write, do_clear;

  // Strictly-greater compare on two BCD digits; ties are not records.
  assign greater = (cap_ten > high_ten) ||
                   ((cap_ten == high_ten) && (cap_one > high_one));

  assign busy = (state != S_IDLE);

  // State register; doneSave is registered off the next state so it rises
  // on entry to S_ACK and drops on the same edge the FSM returns to idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      tmr.doneSave <= 1'b0;
    end else begin
      state        <= nxt;
      tmr.doneSave <= (nxt == S_ACK);
    end
  end

  // Next-state and datapath strobes; done outranks clear_high in idle.
  always_comb begin
    nxt        = state;
    do_capture = 1'b0;
    do_write   = 1'b0;
    do_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tmr.done)      nxt      = S_CAPTURE;
        else if (clear_high) do_clear = 1'b1;
      end
      S_CAPTURE: begin
        do_capture = 1'b1;
        nxt        = S_COMPARE;
      end
      S_COMPARE: nxt = greater ? S_WRITE : S_ACK;
      S_WRITE: begin
        do_write = 1'b1;
        nxt      = S_ACK;
      end
      S_ACK: if (!tmr.done) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Capture registers, high score and record flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cap_ten    <= '0;
      cap_one    <= '0;
      high_ten   <= INIT_TEN;
      high_one   <= INIT_ONE;
      new_record <= 1'b0;
    end else begin
      if (do_capture) begin
        cap_ten    <= bcd_sat(tmr.score_ten);
        cap_one    <= bcd_sat(tmr.score_one);
        new_record <= 1'b0;
      end
      if (do_write) begin
        high_ten   <= cap_ten;
        high_one   <= cap_one;
        new_record <= 1'b1;
      end
      if (do_clear) begin
        high_ten <= INIT_TEN;
        high_one <= INIT_ONE;
      end
    end
  end

  score_save_flash #(
    .FLASH_PERIOD  (FLASH_PERIOD),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash (
    .clk          (clk),
    .resetn       (resetn),
    .start        (do_write),
    .abort        (do_capture),
    .record_flash (record_flash)
  );

endmodule

// File: tb/tb_score_save.sv
// Bench for score_save: reset check, a flash-sequence walk, a table of
// directed saves, reset/clear corner cases, then randomized saves checked
// against a numeric high-score model.
module tb_score_save;
  import score_save_pkg::*;

  localparam int P = 4;
  localparam int T = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_high = 1'b0;
  logic [3:0] high_ten, high_one;
  logic       new_record, record_flash, busy;

  score_save_if tif();

  always #5 clk = ~clk;

  score_save #(
    .HIGH_INIT_TEN (0),
    .HIGH_INIT_ONE (0),
    .FLASH_PERIOD  (P),
    .FLASH_TOGGLES (T)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .tmr          (tif),
    .clear_high   (clear_high),
    .high_ten     (high_ten),
    .high_one     (high_one),
    .new_record   (new_record),
    .record_flash (record_flash),
    .busy         (busy)
  );

  int nvec  = 0;
  int nfail = 0;
  int model_high = 0;

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    int         exp_high;
    bit         exp_rec;
    int         hold;
    bit         pulse;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  // One complete save transaction. pulse: done lasts one sampled cycle.
  // clr: clear_high asserted alongside done in the accepting cycle.
  task automatic save(input string name, input logic [3:0] t, input logic [3:0] o,
                      input int exp_high, input bit exp_rec, input int hold,
                      input bit pulse, input bit clr);
    int lat;
    tif.score_ten = t;
    tif.score_one = o;
    tif.done      = 1'b1;
    clear_high    = clr;
    tick;
    lat = 1;
    clear_high = 1'b0;
    if (pulse) tif.done = 1'b0;
    while (tif.doneSave !== 1'b1 && lat < 12) begin
      tick;
      lat++;
    end
    chk({name, ".latency"}, lat, exp_rec ? 4 : 3);
    chk({name, ".high"}, high_ten * 10 + high_one, exp_high);
    chk({name, ".new_record"}, new_record, int'(exp_rec));
    if (!pulse) begin
      repeat (hold) tick;
      if (hold > 0) chk({name, ".ack_held"}, tif.doneSave, 1);
      tif.done = 1'b0;
    end
    tick;
    chk({name, ".ack_drop"}, tif.doneSave, 0);
    chk({name, ".idle"}, busy, 0);
    model_high = exp_high;
  endtask

  initial begin
    tif.done = 1'b0;
    tif.score_ten = 4'd0;
    tif.score_one = 4'd0;

    tbl[0] = '{4'd3, 4'd7, 37, 1'b0, 1, 1'b0};
    tbl[1] = '{4'd2, 4'd9, 37, 1'b0, 0, 1'b0};
    tbl[2] = '{4'd3, 4'd6, 37, 1'b0, 2, 1'b0};
    tbl[3] = '{4'd4, 4'd0, 40, 1'b1, 0, 1'b0};
    tbl[4] = '{4'hC, 4'd5, 95, 1'b1, 1, 1'b0};
    tbl[5] = '{4'd9, 4'd4, 95, 1'b0, 0, 1'b1};
    tbl[6] = '{4'hF, 4'hF, 99, 1'b1, 0, 1'b1};
    tbl[7] = '{4'd9, 4'd9, 99, 1'b0, 0, 1'b0};

    // Reset and idle
    tick; tick;
    resetn = 1'b1;
    repeat (5) tick;
    chk("rst.high", high_ten * 10 + high_one, 0);
    chk("rst.doneSave", tif.doneSave, 0);
    chk("rst.busy", busy, 0);
    chk("rst.new_record", new_record, 0);
    chk("rst.flash", record_flash, 0);

    // First record with done held; walk the flash sequence alongside
    begin
      int lat;
      int k;
      tif.score_ten = 4'd3;
      tif.score_one = 4'd7;
      tif.done = 1'b1;
      lat = 0;
      while (tif.doneSave !== 1'b1 && lat < 12) begin
        tick;
        lat++;
      end
      chk("rec37.latency", lat, 4);
      chk("rec37.high", high_ten * 10 + high_one, 37);
      chk("rec37.new_record", new_record, 1);
      chk("rec37.flash0", record_flash, 0);
      for (int c = 1; c <= P * T + 4; c++) begin
        tick;
        k = c / P;
        if (k > T) k = T;
        chk("rec37.flash", record_flash, k % 2);
        if (c == 1) chk("rec37.ack_held", tif.doneSave, 1);
        if (c == 2) tif.done = 1'b0;
        if (c == 3) begin
          chk("rec37.ack_drop", tif.doneSave, 0);
          chk("rec37.idle", busy, 0);
        end
      end
      model_high = 37;
    end

    // Directed table
    for (int i = 0; i < 8; i++)
      save($sformatf("tbl%0d", i), tbl[i].t, tbl[i].o, tbl[i].exp_high,
           tbl[i].exp_rec, tbl[i].hold, tbl[i].pulse, 1'b0);

    // Clear in idle
    clear_high = 1'b1;
    tick;
    clear_high = 1'b0;
    chk("clear.high", high_ten * 10 + high_one, 0);
    model_high = 0;

    // Reset while comparing a would-be record
    tif.score_ten = 4'd9;
    tif.score_one = 4'd9;
    tif.done = 1'b1;
    tick;            // accepted -> capture
    tick;            // captured -> compare
    chk("rstmid.busy_before", busy, 1);
    resetn = 1'b0;
    tick;
    chk("rstmid.high", high_ten * 10 + high_one, 0);
    chk("rstmid.doneSave", tif.doneSave, 0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.new_record", new_record, 0);
    chk("rstmid.flash", record_flash, 0);
    tif.done = 1'b0;
    resetn = 1'b1;
    repeat (3) tick;
    chk("rstmid.high_after", high_ten * 10 + high_one, 0);
    chk("rstmid.idle_after", busy, 0);

    // clear_high coincident with done: save wins, no clear
    save("pre50", 4'd5, 4'd0, 50, 1'b1, 0, 1'b0, 1'b0);
    save("clrdone", 4'd2, 4'd0, 50, 1'b0, 0, 1'b0, 1'b1);

    // Randomized saves against the numeric model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] t, o;
      int v;
      bit rec;
      if ($urandom_range(0, 4) == 0) begin
        clear_high = 1'b1;
        tick;
        clear_high = 1'b0;
        model_high = 0;
        chk("rnd.clear", high_ten * 10 + high_one, 0);
      end
      t = 4'($urandom_range(0, 15));
      o = 4'($urandom_range(0, 15));
      v = sat(t) * 10 + sat(o);
      rec = (v > model_high);
      save($sformatf("rnd%0d", i), t, o, rec ? v : model_high, rec,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
